// File: rtl/reverse_arbiter.sv
// Two-requester round-robin front end for a shared 32-bit bit-reverse / byte-swap
// unit, with a single-entry output register and a wrapping consumed-result counter.
module reverse_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [31:0]      req0_data,
    input  logic             req0_mode,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [31:0]      req1_data,
    input  logic             req1_mode,
    output logic             req1_ready,
    output logic             out_valid,
    output logic [31:0]      out_data,
    output logic             out_id,
    input  logic             out_ready,
    output logic [CNT_W-1:0] op_count
);

    logic             r_out_valid;
    logic [31:0]      r_out_data;
    logic             r_out_id;
    logic [CNT_W-1:0] r_op_count;
    logic             r_last_grant;

    logic        w_slot_free;
    logic        w_consume;
    logic        w_grant0;
    logic        w_grant1;
    logic        w_grant;
    logic [31:0] w_sel_data;
    logic        w_sel_mode;
    logic [31:0] w_bitrev;
    logic [31:0] w_byteswap;
    logic [31:0] w_result;

    assign w_slot_free = !r_out_valid | out_ready;
    assign w_consume   = r_out_valid & out_ready;

    // On a tie the requester that did not win last time gets the slot.
    assign w_grant0 = w_slot_free & req0_valid & (!req1_valid |  r_last_grant);
    assign w_grant1 = w_slot_free & req1_valid & (!req0_valid | !r_last_grant);
    assign w_grant  = w_grant0 | w_grant1;

    assign w_sel_data = w_grant1 ? req1_data : req0_data;
    assign w_sel_mode = w_grant1 ? req1_mode : req0_mode;

    for (genvar i = 0; i < 32; i++) begin : g_rev
        assign w_bitrev[i] = w_sel_data[31-i];
    end

    assign w_byteswap = {w_sel_data[7:0], w_sel_data[15:8],
                         w_sel_data[23:16], w_sel_data[31:24]};
    assign w_result   = w_sel_mode ? w_byteswap : w_bitrev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_id     <= 1'b0;
            r_op_count   <= '0;
            r_last_grant <= 1'b1;
        end else begin
            if (w_consume)
                r_op_count <= r_op_count + 1'b1;
            if (w_grant) begin
                r_out_valid  <= 1'b1;
                r_out_data   <= w_result;
                r_out_id     <= w_grant1;
                r_last_grant <= w_grant1;
            end else if (w_consume) begin
                // Data is left in place; only the valid flag drops.
                r_out_valid <= 1'b0;
            end
        end
    end

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_id     = r_out_id;
    assign op_count   = r_op_count;

endmodule
